// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request path: core id, request packet and the
// pointer-width helper used by the round-robin arbiter.
package l2_request_arbiter_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef struct packed {
        logic        valid;
        core_id_t    core;
        logic        store;
        logic [31:0] address;
    } l2req_packet_t;

    // Pointer width for an N-way arbiter; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched upward from last_grant+1,
// pointer advances only when the caller reports a transfer on update_lru.
module rr_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 4,
    localparam int PW             = ptr_width(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    logic [PW-1:0] last_grant_q;
    logic [PW-1:0] last_grant_d;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand_idx;
    logic          found;
    int            cand;

    // Explicit modulo wrap so non-power-of-two counts never visit unused indices.
    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = int'(last_grant_q) + 1 + i;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - NUM_REQUESTERS;
            end
            cand_idx = PW'(cand);
            if (!found && request[cand_idx]) begin
                grant_oh[cand_idx] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_oh[i]) begin
                grant_idx = PW'(i);
            end
        end
        last_grant_d = update_lru ? grant_idx : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= PW'(NUM_REQUESTERS - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Merges per-core L2 requests into one registered stream stamped with the source core.
// l2r_stall reaches l2_ready combinationally (through can_load); that path is intended.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQUESTERS = NUM_CORES,
    localparam int PW             = ptr_width(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  l2req_packet_t             l2i_request [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] l2_ready,
    input  logic                      l2r_stall,
    output l2req_packet_t             l2a_request
);

    localparam int PKT_W = $bits(l2req_packet_t);

    l2req_packet_t             l2a_request_q;
    l2req_packet_t             l2a_request_d;
    l2req_packet_t             sel_pkt;
    logic [PKT_W-1:0]          sel_bits;
    logic [PW-1:0]             grant_idx;
    logic [NUM_REQUESTERS-1:0] valid_vec;
    logic [NUM_REQUESTERS-1:0] arb_request;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      can_load;
    logic                      transfer;

    assign can_load = !l2a_request_q.valid || !l2r_stall;

    // Masking the requests (not the grant) keeps the pointer frozen while stalled or in reset.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            valid_vec[i] = l2i_request[i].valid;
        end
        arb_request = (can_load && !reset) ? valid_vec : '0;
    end

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .request   (arb_request),
        .update_lru(transfer),
        .grant_oh  (grant_oh)
    );

    assign l2_ready = grant_oh;
    assign transfer = |grant_oh;

    always_comb begin
        sel_bits  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_oh[i]) begin
                sel_bits  = sel_bits | l2i_request[i];
                grant_idx = PW'(i);
            end
        end
        sel_pkt       = l2req_packet_t'(sel_bits);
        sel_pkt.core  = CORE_ID_W'(grant_idx);
        sel_pkt.valid = 1'b1;
    end

    always_comb begin
        l2a_request_d = l2a_request_q;
        if (transfer) begin
            l2a_request_d = sel_pkt;
        end else if (!l2r_stall) begin
            l2a_request_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2a_request_q <= '0;
        end else begin
            l2a_request_q <= l2a_request_d;
        end
    end

    assign l2a_request = l2a_request_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter with four requesters and hand-computed expectations.
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          l2r_stall;
    l2req_packet_t l2i_request [N];
    logic [N-1:0]  l2_ready;
    l2req_packet_t l2a_request;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_request_arbiter #(
        .NUM_REQUESTERS(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l2i_request(l2i_request),
        .l2_ready   (l2_ready),
        .l2r_stall  (l2r_stall),
        .l2a_request(l2a_request)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Incoming core field is garbage on purpose; the DUT must overwrite it.
    task automatic drive(input int c, input logic v, input logic [31:0] a);
        l2i_request[c].valid   = v;
        l2i_request[c].core    = core_id_t'(2'b11);
        l2i_request[c].store   = a[4];
        l2i_request[c].address = a;
    endtask

    task automatic clear_all();
        for (int c = 0; c < N; c++) begin
            drive(c, 1'b0, 32'h0);
        end
    endtask

    function automatic logic [63:0] exp_pkt(input int c, input logic [31:0] a);
        l2req_packet_t p;
        p.valid   = 1'b1;
        p.core    = core_id_t'(c);
        p.store   = a[4];
        p.address = a;
        return 64'(p);
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        l2r_stall = 1'b0;
        clear_all();
        drive(1, 1'b1, 32'h55);
        #1;
        check_eq("rst_ready", 64'(l2_ready), 64'(4'b0000));
        check_eq("rst_out", 64'(l2a_request), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        clear_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        l2r_stall = 1'b0;
        clear_all();

        // Reset priority: core 1 wins over core 3, then 3, then 1 again.
        do_reset();
        drive(1, 1'b1, 32'h100);
        drive(3, 1'b1, 32'h300);
        #1;
        check_eq("rp_ready0", 64'(l2_ready), 64'(4'b0010));
        tick();
        check_eq("rp_out0", 64'(l2a_request), exp_pkt(1, 32'h100));
        drive(1, 1'b1, 32'h110);
        #1;
        check_eq("rp_ready1", 64'(l2_ready), 64'(4'b1000));
        tick();
        check_eq("rp_out1", 64'(l2a_request), exp_pkt(3, 32'h300));
        drive(3, 1'b0, 32'h0);
        #1;
        check_eq("rp_ready2", 64'(l2_ready), 64'(4'b0010));
        tick();
        check_eq("rp_out2", 64'(l2a_request), exp_pkt(1, 32'h110));
        clear_all();
        tick();
        check_eq("rp_drain", 64'(l2a_request.valid), 64'(1'b0));

        // Saturation: all cores valid, grants rotate 0,1,2,3 with no bubble.
        do_reset();
        for (int c = 0; c < N; c++) begin
            drive(c, 1'b1, 32'(c * 32'h40));
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << (i % 4);
            #1;
            check_eq("sat_ready", 64'(l2_ready), 64'(exp_rdy));
            tick();
            check_eq("sat_out", 64'(l2a_request), exp_pkt(i % 4, 32'((i % 4) * 32'h40)));
        end
        clear_all();
        tick();

        // Stall hold: register keeps core 2's packet, no ready until stall drops.
        do_reset();
        drive(2, 1'b1, 32'h1000);
        #1;
        check_eq("st_ready_load", 64'(l2_ready), 64'(4'b0100));
        tick();
        check_eq("st_out_load", 64'(l2a_request), exp_pkt(2, 32'h1000));
        drive(2, 1'b0, 32'h0);
        drive(0, 1'b1, 32'h2000);
        l2r_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("st_ready_hold", 64'(l2_ready), 64'(4'b0000));
            tick();
            check_eq("st_out_hold", 64'(l2a_request), exp_pkt(2, 32'h1000));
        end
        l2r_stall = 1'b0;
        #1;
        check_eq("st_ready_release", 64'(l2_ready), 64'(4'b0001));
        tick();
        check_eq("st_out_release", 64'(l2a_request), exp_pkt(0, 32'h2000));
        clear_all();
        tick();
        check_eq("st_drain", 64'(l2a_request.valid), 64'(1'b0));

        // Back-to-back from core 3 only; pointer must end at 3 so core 0 wins next.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(3, 1'b1, 32'(k * 16));
            #1;
            check_eq("b2b_ready", 64'(l2_ready), 64'(4'b1000));
            tick();
            check_eq("b2b_out", 64'(l2a_request), exp_pkt(3, 32'(k * 16)));
        end
        drive(3, 1'b1, 32'h50);
        drive(0, 1'b1, 32'h60);
        #1;
        check_eq("b2b_ptr_ready", 64'(l2_ready), 64'(4'b0001));
        tick();
        check_eq("b2b_ptr_out", 64'(l2a_request), exp_pkt(0, 32'h60));
        clear_all();
        tick();

        // Async reset mid-stall: output clears before the next edge, core 0 first after.
        do_reset();
        drive(1, 1'b1, 32'h700);
        #1;
        tick();
        check_eq("ar_load", 64'(l2a_request), exp_pkt(1, 32'h700));
        clear_all();
        l2r_stall = 1'b1;
        tick();
        check_eq("ar_held", 64'(l2a_request), exp_pkt(1, 32'h700));
        #3;
        reset = 1'b1;
        drive(0, 1'b1, 32'h800);
        drive(2, 1'b1, 32'h900);
        #1;
        check_eq("ar_out_async", 64'(l2a_request), 64'h0);
        check_eq("ar_ready_in_reset", 64'(l2_ready), 64'(4'b0000));
        tick();
        check_eq("ar_out_still", 64'(l2a_request), 64'h0);
        reset     = 1'b0;
        l2r_stall = 1'b0;
        #1;
        check_eq("ar_ready_after", 64'(l2_ready), 64'(4'b0001));
        tick();
        check_eq("ar_out_after", 64'(l2a_request), exp_pkt(0, 32'h800));
        clear_all();
        tick();

        // Idle cycles must not move the pointer off core 2.
        do_reset();
        drive(2, 1'b1, 32'hA00);
        #1;
        tick();
        check_eq("idle_load", 64'(l2a_request), exp_pkt(2, 32'hA00));
        clear_all();
        repeat (4) tick();
        check_eq("idle_empty", 64'(l2a_request.valid), 64'(1'b0));
        drive(0, 1'b1, 32'hB00);
        drive(3, 1'b1, 32'hC00);
        #1;
        check_eq("idle_ready0", 64'(l2_ready), 64'(4'b1000));
        tick();
        check_eq("idle_out0", 64'(l2a_request), exp_pkt(3, 32'hC00));
        drive(3, 1'b0, 32'h0);
        #1;
        check_eq("idle_ready1", 64'(l2_ready), 64'(4'b0001));
        tick();
        check_eq("idle_out1", 64'(l2a_request), exp_pkt(0, 32'hB00));
        clear_all();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
